// File: rtl/pulse_reconstruct_mc.sv
// pulse_reconstruct_mc
// Multi-channel edge-to-pulse rebuilder. Each channel turns rise/fall strobes
// back into a level pulse, measures its width in cycles (saturating) and ends
// the pulse early when a shared, programmable max width is reached.
// Channels are fully independent; only max_len is shared.
module pulse_reconstruct_mc #(
    parameter int NUM_CH = 4,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       clear,
    input  logic [NUM_CH-1:0]       rise,
    input  logic [NUM_CH-1:0]       fall,
    input  logic [LEN_W-1:0]        max_len,
    input  logic [NUM_CH-1:0]       err_clr,
    output logic [NUM_CH-1:0]       pulse_out,
    output logic [NUM_CH-1:0]       len_valid,
    output logic [NUM_CH*LEN_W-1:0] len_data,
    output logic [NUM_CH-1:0]       to_err,
    output logic [NUM_CH-1:0]       dup_err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            logic [0:0]       state;
            logic [0:0]       state_nxt;
            logic [LEN_W-1:0] len_cnt;
            logic [LEN_W-1:0] cnt_nxt;
            logic [LEN_W-1:0] width;
            logic [LEN_W-1:0] end_len;
            logic             done;
            logic             to_set;
            logic             dup_set;
            logic             valid_q;
            logic             to_q;
            logic             dup_q;
            logic [LEN_W-1:0] data_q;

            // Pulse width including the current cycle, saturating at all-ones.
            always_comb begin
                width = (len_cnt == LEN_MAX) ? LEN_MAX : len_cnt + LEN_ONE;
            end

            // Next-state, completion and error-set decode; clear overrides every event.
            always_comb begin
                state_nxt = state;
                cnt_nxt   = len_cnt;
                done      = 1'b0;
                end_len   = width;
                to_set    = 1'b0;
                dup_set   = 1'b0;
                if (clear[k]) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (state == ST_IDLE) begin
                    if (rise[k] && fall[k]) begin
                        // Single-cycle pulse: reported without ever entering ACTIVE.
                        done    = 1'b1;
                        end_len = LEN_ONE;
                    end else if (rise[k]) begin
                        state_nxt = ST_ACTIVE;
                        cnt_nxt   = LEN_ONE;
                    end
                end else begin
                    dup_set = rise[k];
                    if (fall[k]) begin
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if ((max_len != '0) && (width >= max_len)) begin
                        done      = 1'b1;
                        to_set    = 1'b1;
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = width;
                    end
                end
            end

            // State, counter, width report and sticky error registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state   <= ST_IDLE;
                    len_cnt <= '0;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    to_q    <= 1'b0;
                    dup_q   <= 1'b0;
                end else begin
                    state   <= state_nxt;
                    len_cnt <= cnt_nxt;
                    valid_q <= done;
                    if (done) begin
                        data_q <= end_len;
                    end
                    if (to_set) begin
                        to_q <= 1'b1;
                    end else if (err_clr[k]) begin
                        to_q <= 1'b0;
                    end
                    if (dup_set) begin
                        dup_q <= 1'b1;
                    end else if (err_clr[k]) begin
                        dup_q <= 1'b0;
                    end
                end
            end

            assign pulse_out[k] = (((state == ST_IDLE) && rise[k]) || (state == ST_ACTIVE))
                                  && !clear[k];
            assign len_valid[k] = valid_q;
            assign len_data[k*LEN_W +: LEN_W] = data_q;
            assign to_err[k]    = to_q;
            assign dup_err[k]   = dup_q;
        end
    endgenerate

endmodule

// File: tb/tb_pulse_reconstruct_mc.sv
// Testbench for pulse_reconstruct_mc: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a behavioural channel model.
module tb_pulse_reconstruct_mc;

    localparam int NUM_CH = 4;
    localparam int LEN_W  = 16;
    localparam int unsigned SAT = (1 << LEN_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       clear, rise, fall, err_clr;
    logic [LEN_W-1:0]        max_len;
    logic [NUM_CH-1:0]       pulse_out, len_valid, to_err, dup_err;
    logic [NUM_CH*LEN_W-1:0] len_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: is the pulse high, how many cycles so far, last reports.
    bit          m_high  [NUM_CH];
    int unsigned m_len   [NUM_CH];
    bit          m_valid [NUM_CH];
    int unsigned m_data  [NUM_CH];
    bit          m_to    [NUM_CH];
    bit          m_dup   [NUM_CH];
    int unsigned m_done_cnt [NUM_CH];
    int unsigned dut_done_cnt [NUM_CH];

    pulse_reconstruct_mc #(.NUM_CH(NUM_CH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .rise(rise), .fall(fall),
        .max_len(max_len), .err_clr(err_clr), .pulse_out(pulse_out),
        .len_valid(len_valid), .len_data(len_data), .to_err(to_err), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    function automatic logic [LEN_W-1:0] data_of(input int ch);
        return len_data[ch*LEN_W +: LEN_W];
    endfunction

    task automatic idle_inputs();
        clear = '0; rise = '0; fall = '0; err_clr = '0;
    endtask

    // One clock cycle with the currently driven inputs: compare DUT against the
    // model at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        bit          n_high [NUM_CH];
        int unsigned n_len  [NUM_CH];
        bit          n_valid[NUM_CH];
        int unsigned n_data [NUM_CH];
        bit          n_to   [NUM_CH];
        bit          n_dup  [NUM_CH];
        @(negedge clk);
        for (int k = 0; k < NUM_CH; k++) begin
            bit exp_p;
            exp_p = (m_high[k] || rise[k]) && !clear[k];
            checks++;
            if (pulse_out[k] !== exp_p) begin
                failures++;
                $display("FAIL pulse_out ch%0d cyc%0d got %b exp %b", k, cyc, pulse_out[k], exp_p);
            end
            checks++;
            if (len_valid[k] !== m_valid[k]) begin
                failures++;
                $display("FAIL len_valid ch%0d cyc%0d got %b exp %b", k, cyc, len_valid[k], m_valid[k]);
            end
            checks++;
            if (data_of(k) !== LEN_W'(m_data[k])) begin
                failures++;
                $display("FAIL len_data ch%0d cyc%0d got %0d exp %0d", k, cyc, data_of(k), m_data[k]);
            end
            checks++;
            if (to_err[k] !== m_to[k] || dup_err[k] !== m_dup[k]) begin
                failures++;
                $display("FAIL errors ch%0d cyc%0d got to=%b dup=%b exp to=%b dup=%b",
                         k, cyc, to_err[k], dup_err[k], m_to[k], m_dup[k]);
            end
            if (len_valid[k] === 1'b1) dut_done_cnt[k]++;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            int unsigned w;
            bit ended, to_hit, dup_hit;
            n_high[k] = m_high[k]; n_len[k] = m_len[k];
            n_data[k] = m_data[k];
            ended = 0; to_hit = 0; dup_hit = 0; w = 0;
            if (clear[k]) begin
                n_high[k] = 0; n_len[k] = 0;
            end else if (!m_high[k]) begin
                if (rise[k] && fall[k]) begin ended = 1; w = 1; end
                else if (rise[k]) begin n_high[k] = 1; n_len[k] = 1; end
            end else begin
                w = (m_len[k] + 1 > SAT) ? SAT : m_len[k] + 1;
                dup_hit = rise[k];
                if (fall[k]) ended = 1;
                else if (max_len != 0 && w >= max_len) begin ended = 1; to_hit = 1; end
                else n_len[k] = w;
            end
            if (ended) begin n_high[k] = 0; n_len[k] = 0; n_data[k] = w; end
            n_valid[k] = ended;
            n_to[k]  = to_hit  ? 1'b1 : (err_clr[k] ? 1'b0 : m_to[k]);
            n_dup[k] = dup_hit ? 1'b1 : (err_clr[k] ? 1'b0 : m_dup[k]);
            if (rst) begin
                n_high[k] = 0; n_len[k] = 0; n_valid[k] = 0; n_data[k] = 0;
                n_to[k] = 0; n_dup[k] = 0;
            end
        end
        @(posedge clk);
        for (int k = 0; k < NUM_CH; k++) begin
            m_high[k] = n_high[k]; m_len[k] = n_len[k]; m_valid[k] = n_valid[k];
            m_data[k] = n_data[k]; m_to[k] = n_to[k]; m_dup[k] = n_dup[k];
            if (n_valid[k]) m_done_cnt[k]++;
        end
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        idle_inputs(); max_len = '0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (pulse_out !== '0 || len_valid !== '0 || len_data !== '0 || to_err !== '0 || dup_err !== '0) begin
            failures++;
            $display("FAIL reset_state got p=%b v=%b d=%h to=%b dup=%b exp all zero",
                     pulse_out, len_valid, len_data, to_err, dup_err);
        end
        ticks(3);
    endtask

    task automatic test_basic();
        idle_inputs(); rise[0] = 1; tick();
        ticks(3);
        fall[0] = 1; tick();
        checks++;
        if (len_valid[0] !== 1'b1 || data_of(0) !== 16'd5) begin
            failures++;
            $display("FAIL basic_width got v=%b len=%0d exp v=1 len=5", len_valid[0], data_of(0));
        end
        ticks(2);
    endtask

    task automatic test_same_cycle();
        idle_inputs(); rise[1] = 1; fall[1] = 1; tick();
        checks++;
        if (len_valid[1] !== 1'b1 || data_of(1) !== 16'd1 || to_err[1] !== 1'b0 || dup_err[1] !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle got v=%b len=%0d to=%b dup=%b exp 1 1 0 0",
                     len_valid[1], data_of(1), to_err[1], dup_err[1]);
        end
        ticks(2);
    endtask

    task automatic test_timeout();
        max_len = 16'd8;
        idle_inputs(); rise[2] = 1; tick();
        ticks(7);
        checks++;
        if (to_err[2] !== 1'b1 || data_of(2) !== 16'd8 || pulse_out[2] !== 1'b0) begin
            failures++;
            $display("FAIL timeout got to=%b len=%0d p=%b exp to=1 len=8 p=0",
                     to_err[2], data_of(2), pulse_out[2]);
        end
        idle_inputs(); fall[2] = 1; tick();
        ticks(1);
        max_len = '0;
        idle_inputs(); err_clr[2] = 1; tick();
        checks++;
        if (to_err[2] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clr got to=%b exp 0", to_err[2]);
        end
        ticks(2);
    endtask

    task automatic test_dup();
        idle_inputs(); rise[3] = 1; tick();
        ticks(1);
        idle_inputs(); rise[3] = 1; tick();
        ticks(2);
        idle_inputs(); fall[3] = 1; tick();
        checks++;
        if (dup_err[3] !== 1'b1 || data_of(3) !== 16'd6 || to_err[3] !== 1'b0) begin
            failures++;
            $display("FAIL dup got dup=%b len=%0d to=%b exp 1 6 0", dup_err[3], data_of(3), to_err[3]);
        end
        idle_inputs(); err_clr[3] = 1; tick();
        checks++;
        if (dup_err[3] !== 1'b0) begin
            failures++;
            $display("FAIL dup_clr got dup=%b exp 0", dup_err[3]);
        end
        ticks(2);
    endtask

    task automatic test_clear_and_rst();
        idle_inputs(); rise[0] = 1; tick();
        ticks(2);
        idle_inputs(); clear[0] = 1; rise[1] = 1; tick();
        ticks(2);
        checks++;
        if (pulse_out[0] !== 1'b0 || len_valid[0] !== 1'b0 || pulse_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL clear got p0=%b v0=%b p1=%b exp 0 0 1", pulse_out[0], len_valid[0], pulse_out[1]);
        end
        idle_inputs(); rst = 1'b1; tick();
        rst = 1'b0;
        checks++;
        if (pulse_out !== '0 || to_err !== '0 || dup_err !== '0 || len_data !== '0) begin
            failures++;
            $display("FAIL mid_rst got p=%b to=%b dup=%b d=%h exp all zero", pulse_out, to_err, dup_err, len_data);
        end
        ticks(2);
    endtask

    task automatic test_lower_max_len();
        max_len = '0;
        idle_inputs(); rise[0] = 1; tick();
        ticks(5);
        max_len = 16'd3;
        tick();
        checks++;
        if (len_valid[0] !== 1'b1 || data_of(0) !== 16'd7 || to_err[0] !== 1'b1) begin
            failures++;
            $display("FAIL lower_max got v=%b len=%0d to=%b exp 1 7 1", len_valid[0], data_of(0), to_err[0]);
        end
        max_len = '0;
        idle_inputs(); err_clr = '1; tick();
        ticks(1);
    endtask

    task automatic test_back_to_back();
        idle_inputs(); rise[1] = 1; tick();
        idle_inputs(); fall[1] = 1; tick();
        idle_inputs(); rise[1] = 1; tick();
        checks++;
        if (len_valid[1] !== 1'b0 || data_of(1) !== 16'd2 || pulse_out[1] !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back got v=%b len=%0d p=%b exp 0 2 1", len_valid[1], data_of(1), pulse_out[1]);
        end
        idle_inputs(); fall[1] = 1; tick();
        ticks(2);
    endtask

    task automatic test_random();
        max_len = '0;
        for (int i = 0; i < 800; i++) begin
            idle_inputs();
            for (int k = 0; k < NUM_CH; k++) begin
                rise[k]    = ($urandom_range(0, 5) == 0);
                fall[k]    = ($urandom_range(0, 4) == 0);
                clear[k]   = ($urandom_range(0, 60) == 0);
                err_clr[k] = ($urandom_range(0, 20) == 0);
            end
            if (i == 400) max_len = 16'd6;
            tick();
        end
        max_len = '0;
        ticks(3);
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (dut_done_cnt[k] !== m_done_cnt[k]) begin
                failures++;
                $display("FAIL random_count ch%0d got %0d exp %0d", k, dut_done_cnt[k], m_done_cnt[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; max_len = '0; idle_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            m_high[k] = 0; m_len[k] = 0; m_valid[k] = 0; m_data[k] = 0;
            m_to[k] = 0; m_dup[k] = 0; m_done_cnt[k] = 0; dut_done_cnt[k] = 0;
        end
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_same_cycle();
        test_timeout();
        test_dup();
        test_clear_and_rst();
        test_lower_max_len();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
